// File: rtl/score_counter.sv
// Game score generator: IDLE/RUN/OVER sequencing, prescaled score, speed level, best score.
// Optional SCORE_HISCORE_EN builds the hi_score register; otherwise hi_score is tied to 0.
module score_counter #(
  parameter int SCORE_W    = 13,
  parameter int TICK_DIV   = 50,
  parameter int MAX_SCORE  = 6399,
  parameter int LEVEL_STEP = 100
) (
  input  logic               clk2,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [2:0]         level,
  output logic               running,
  output logic               game_over
);

  // state  | meaning
  // S_IDLE | power-up, waiting for the first start edge
  // S_RUN  | score advancing at the prescaled rate
  // S_OVER | score frozen after a collision, waiting for restart
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int STEP_W  = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(LEVEL_STEP - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

  state_t             state, state_nxt;
  logic               start_d;
  logic               start_edge;
  logic               tick;
  logic               inc;
  logic [PRESC_W-1:0] presc;
  logic [STEP_W-1:0]  step;

  assign start_edge = start & ~start_d;
  assign tick       = (state == S_RUN) && (presc == PRESC_LAST);
  // hit wins over a same-cycle tick, so that increment is dropped
  assign inc        = tick && !hit && (score != SCORE_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_edge) state_nxt = S_RUN;
      S_RUN:   if (hit)        state_nxt = S_OVER;
      S_OVER:  if (start_edge) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      start_d   <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_d   <= start;
      running   <= (state_nxt == S_RUN);
      game_over <= (state_nxt == S_OVER);
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      score <= '0;
      level <= '0;
      presc <= '0;
      step  <= '0;
    end else if ((state != S_RUN) && start_edge) begin
      score <= '0;
      level <= '0;
      presc <= '0;
      step  <= '0;
    end else if ((state == S_RUN) && !hit) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      if (inc) begin
        score <= score + 1'b1;
        if (step == STEP_LAST) begin
          step <= '0;
          if (level != 3'd7) level <= level + 3'd1;
        end else begin
          step <= step + 1'b1;
        end
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  // compares the frozen score on the RUN -> OVER edge
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset)
      hi_score <= '0;
    else if ((state == S_RUN) && hit && (score > hi_score))
      hi_score <= score;
  end
`else
  assign hi_score = '0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter with a cycle-count based reference model.
module tb_score_counter;
  localparam int SW = 13;
  localparam int TD = 4;
  localparam int MS = 12;
  localparam int LS = 5;

  logic          clk2 = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          hit = 1'b0;
  logic [SW-1:0] score, hi_score;
  logic [2:0]    level;
  logic          running, game_over;

  int tests_run = 0;
  int tests_failed = 0;

  score_counter #(.SCORE_W(SW), .TICK_DIV(TD), .MAX_SCORE(MS), .LEVEL_STEP(LS)) dut (
    .clk2(clk2), .reset(reset), .start(start), .hit(hit),
    .score(score), .hi_score(hi_score), .level(level),
    .running(running), .game_over(game_over)
  );

  always #5 clk2 = ~clk2;

  // Model: score is the number of hit-free RUN cycles divided by TD, clipped.
  typedef enum {M_IDLE, M_RUN, M_OVER} mstate_t;
  mstate_t m_state;
  int      m_cnt;
  int      m_hi;
  bit      m_sd;

  function automatic int e_score();
    int s;
    s = m_cnt / TD;
    return (s > MS) ? MS : s;
  endfunction

  function automatic int e_level();
    int l;
    l = e_score() / LS;
    return (l > 7) ? 7 : l;
  endfunction

  function automatic int e_hi();
`ifdef SCORE_HISCORE_EN
    return m_hi;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_hi    = 0;
    m_sd    = 1'b0;
  endtask

  // Advance one clock; inputs are sampled at the edge and the model follows.
  task automatic cyc();
    bit s, h;
    s = start;
    h = hit;
    @(posedge clk2);
    #1;
    if (s && !m_sd && m_state != M_RUN) begin
      m_state = M_RUN;
      m_cnt   = 0;
    end else if (m_state == M_RUN) begin
      if (h) begin
        m_state = M_OVER;
        if (e_score() > m_hi) m_hi = e_score();
      end else begin
        m_cnt++;
      end
    end
    m_sd = s;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0; start = 1'b0; hit = 1'b0;
    #12;
    tests_run++;
    if ({score, hi_score, level, running, game_over} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: score=%0d hi=%0d level=%0d run=%b over=%b, required all 0",
               score, hi_score, level, running, game_over);
    end
    reset = 1'b1;
  endtask

  task automatic test_start_ticks();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests_run++;
    if (running !== 1'b1 || score !== '0) begin
      tests_failed++;
      $display("FAIL start_entry: running=%b score=%0d, required 1 and 0", running, score);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i % 4 == 0) begin
        tests_run++;
        if (score !== SW'(i / 4)) begin
          tests_failed++;
          $display("FAIL tick_%0d: score=%0d, required %0d", i, score, i / 4);
        end
      end
    end
  endtask

  task automatic test_hit_on_tick();
    int n;
    n = 0;
    while (m_cnt != 31 && n < 100) begin
      cyc();
      n++;
      tests_run++;
      if (score !== SW'(e_score()) || level !== 3'(e_level())) begin
        tests_failed++;
        $display("FAIL climb_to_7: score=%0d level=%0d, required %0d %0d",
                 score, level, e_score(), e_level());
      end
    end
    tests_run++;
    if (m_cnt != 31 || score !== SW'(7)) begin
      tests_failed++;
      $display("FAIL pre_hit: score=%0d, required 7 on tick cycle (budget %0d)", score, n);
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    tests_run++;
`ifdef SCORE_HISCORE_EN
    if (game_over !== 1'b1 || running !== 1'b0 || score !== SW'(7) || hi_score !== SW'(7)) begin
`else
    if (game_over !== 1'b1 || running !== 1'b0 || score !== SW'(7) || hi_score !== '0) begin
`endif
      tests_failed++;
      $display("FAIL hit_on_tick: over=%b run=%b score=%0d hi=%0d, required 1 0 7 %0d",
               game_over, running, score, hi_score, e_hi());
    end
    repeat (6) begin
      hit = 1'($urandom_range(0, 1));
      cyc();
    end
    hit = 1'b0;
    tests_run++;
    if (score !== SW'(7) || game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL over_hold: score=%0d over=%b, required 7 1", score, game_over);
    end
  endtask

  task automatic test_restart_held();
    int n;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      tests_run++;
      if (running !== 1'b1 || score !== SW'(e_score())) begin
        tests_failed++;
        $display("FAIL held_start_%0d: run=%b score=%0d, required 1 %0d", i, running, score, e_score());
      end
    end
    start = 1'b0;
    n = 0;
    while (m_cnt < 12 && n < 50) begin
      cyc();
      n++;
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    tests_run++;
`ifdef SCORE_HISCORE_EN
    if (score !== SW'(3) || hi_score !== SW'(7) || game_over !== 1'b1) begin
`else
    if (score !== SW'(3) || hi_score !== '0 || game_over !== 1'b1) begin
`endif
      tests_failed++;
      $display("FAIL restart_held: score=%0d hi=%0d over=%b, required 3 %0d 1",
               score, hi_score, game_over, e_hi());
    end
  endtask

  task automatic test_level_saturation();
    bit seen5, seen10;
    seen5 = 0; seen10 = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      tests_run++;
      if (score !== SW'(e_score()) || level !== 3'(e_level())) begin
        tests_failed++;
        $display("FAIL level_run_%0d: score=%0d level=%0d, required %0d %0d",
                 i, score, level, e_score(), e_level());
      end
      if (score == SW'(5) && !seen5) begin
        seen5 = 1;
        tests_run++;
        if (level !== 3'd1) begin
          tests_failed++;
          $display("FAIL level_at_5: level=%0d, required 1", level);
        end
      end
      if (score == SW'(10) && !seen10) begin
        seen10 = 1;
        tests_run++;
        if (level !== 3'd2) begin
          tests_failed++;
          $display("FAIL level_at_10: level=%0d, required 2", level);
        end
      end
    end
    for (int i = 0; i < 25; i++) begin
      cyc();
      tests_run++;
      if (score !== SW'(12) || level !== 3'd2) begin
        tests_failed++;
        $display("FAIL saturate_%0d: score=%0d level=%0d, required 12 2", i, score, level);
      end
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    tests_run++;
    if (hi_score !== SW'(e_hi()) || game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL hi_after_sat: hi=%0d over=%b, required %0d 1", hi_score, game_over, e_hi());
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (m_cnt < 16 && n < 50) begin
      cyc();
      n++;
    end
    tests_run++;
    if (score !== SW'(4)) begin
      tests_failed++;
      $display("FAIL pre_reset: score=%0d, required 4", score);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({score, hi_score, level, running, game_over} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: score=%0d hi=%0d level=%0d run=%b over=%b, required all 0",
               score, hi_score, level, running, game_over);
    end
    model_reset();
    #3 reset = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests_run++;
    if (running !== 1'b1 || score !== '0) begin
      tests_failed++;
      $display("FAIL start_after_reset: run=%b score=%0d, required 1 0", running, score);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 24) == 0);
      hit   = ($urandom_range(0, 39) == 0);
      cyc();
      tests_run++;
      if (score !== SW'(e_score()) || level !== 3'(e_level()) || hi_score !== SW'(e_hi()) ||
          running !== (m_state == M_RUN) || game_over !== (m_state == M_OVER)) begin
        tests_failed++;
        $display("FAIL random_%0d: score=%0d level=%0d hi=%0d run=%b over=%b, required %0d %0d %0d %b %b",
                 i, score, level, hi_score, running, game_over, e_score(), e_level(), e_hi(),
                 m_state == M_RUN, m_state == M_OVER);
      end
    end
    start = 1'b0;
    hit   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_hit_on_tick();
    test_restart_held();
    test_level_saturation();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end
endmodule
